// File: rtl/byte_packer.sv
// byte_packer: packs NUM_BYTES bytes into one word with valid/ready on both sides and partial-word flush
module byte_packer #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        byte_dv,
  input  logic [BYTE_W-1:0]           byte_in,
  output logic                        byte_rdy,
  input  logic                        flush,
  output logic                        word_dv,
  input  logic                        word_rdy,
  output logic [NUM_BYTES*BYTE_W-1:0] word,
  output logic [NUM_BYTES-1:0]        word_be,
  output logic                        busy
);
  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam int WW = NUM_BYTES * BYTE_W;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WW-1:0]        acc_q, acc_d, acc_ins, word_q, word_d;
  logic [NUM_BYTES-1:0] fill_be, word_be_q, word_be_d;
  logic                 flush_pend_q, flush_pend_d, word_dv_q, word_dv_d;
  logic                 take, full, drain;
  for (genvar s = 0; s < NUM_BYTES; s++) begin : g_slot
    localparam int L = MSB_FIRST ? NUM_BYTES - 1 - s : s;
    assign acc_ins[L*BYTE_W +: BYTE_W] = (take && cnt_q == CW'(s)) ? byte_in : acc_q[L*BYTE_W +: BYTE_W];
    assign fill_be[L] = CW'(s) < cnt_q;
  end
  always_comb begin
    byte_rdy = ce & ~flush_pend_q & ((cnt_q != LAST) | ~word_dv_q | word_rdy);
    take = byte_dv & byte_rdy;
    full = take & (cnt_q == LAST);
    drain = ce & flush_pend_q & (~word_dv_q | word_rdy);
    cnt_d = (full | drain) ? '0 : take ? cnt_q + CW'(1) : cnt_q;
    acc_d = (full | drain) ? '0 : acc_ins;
    flush_pend_d = ~drain & (flush_pend_q | (ce & flush & ~full & (take | (cnt_q != '0))));
    word_dv_d = full | drain | (word_dv_q & ~word_rdy);
    word_d = full ? acc_ins : drain ? acc_q : word_q;
    word_be_d = full ? '1 : drain ? fill_be : word_be_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      flush_pend_q <= 1'b0;
      word_dv_q <= 1'b0;
      word_q <= '0;
      word_be_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      flush_pend_q <= flush_pend_d;
      word_dv_q <= word_dv_d;
      word_q <= word_d;
      word_be_q <= word_be_d;
    end
  end
  assign word_dv = word_dv_q;
  assign word = word_q;
  assign word_be = word_be_q;
  assign busy = (cnt_q != '0) | flush_pend_q;
endmodule
